// File: rtl/mem_access_unit.sv
// Memory stage: runs loads/stores on a variable-latency bus, stalls upstream while waiting,
// formats load data and registers the writeback triple. Optional macro: MISALIGN_EXC_EN.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_ex,
    input  logic              wrt_en_ex,
    input  logic [1:0]        width_ex,
    input  logic              unsigned_sel_ex,
    input  logic [ADDR_W-1:0] addr_ex,
    input  logic [31:0]       store_data_ex,
    input  logic [31:0]       next_pc_ex,
    input  logic [1:0]        wb_sel_ex,
    input  logic              write_en_ex,
    input  logic [4:0]        write_reg_ex,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall_mem,
    output logic              write_enable_wb,
    output logic [4:0]        write_reg_wb,
    output logic [31:0]       write_data_wb,
    output logic              misalign_exc
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;

    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_reg_q, wb_reg_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic              access;
    logic              misalign;
    logic              access_ok;
    logic [31:0]       st_wdata;
    logic [3:0]        st_be;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;
    logic [31:0]       alu_val;

    assign access = rd_en_ex | wrt_en_ex;

`ifdef MISALIGN_EXC_EN
    logic misalign_q;

    assign misalign = access &
                      (((width_ex == 2'b01) && addr_ex[0]) ||
                       (width_ex[1] && (addr_ex[1:0] != 2'b00)));
    assign misalign_exc = misalign_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign & ~stall_mem;
        end
    end
`else
    assign misalign     = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    assign access_ok = access & ~misalign;

    // The ack cycle itself does not stall, so the WB registers capture mem_rdata on that edge.
    assign stall_mem = ((state_q == IDLE) & access_ok) | ((state_q == BUSY) & ~mem_ack);

    assign alu_val = 32'(addr_ex);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        st_wdata = store_data_ex;
        st_be    = 4'b1111;
        case (width_ex)
            2'b00: begin
                st_wdata = {4{store_data_ex[7:0]}};
                st_be    = 4'b0001 << addr_ex[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data_ex[15:0]}};
                st_be    = addr_ex[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = store_data_ex;
                st_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte   = mem_rdata[7:0];
        ld_half   = addr_ex[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (addr_ex[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        case (width_ex)
            2'b00:   load_data = unsigned_sel_ex ? {24'h0, ld_byte}
                                                 : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_data = unsigned_sel_ex ? {16'h0, ld_half}
                                                 : {{16{ld_half[15]}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (access_ok) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = wrt_en_ex;
                    addr_d  = {addr_ex[ADDR_W-1:2], 2'b00};
                    wdata_d = st_wdata;
                    be_d    = wrt_en_ex ? st_be : 4'b1111;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        wb_en_d   = write_en_ex & ~wrt_en_ex & (write_reg_ex != 5'd0) & ~misalign;
        wb_reg_d  = write_reg_ex;
        wb_data_d = alu_val;
        case (wb_sel_ex)
            2'b01:   wb_data_d = load_data;
            2'b10:   wb_data_d = next_pc_ex;
            default: wb_data_d = alu_val;
        endcase
    end

    // A stalled slot becomes a bubble: enable drops, reg/data hold their last values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else if (stall_mem) begin
            wb_en_q   <= 1'b0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_be          = be_q;
    assign write_enable_wb = wb_en_q;
    assign write_reg_wb    = wb_reg_q;
    assign write_data_wb   = wb_data_q;

endmodule
